// File: rtl/mips_multicycle.sv
// Multicycle MIPS subset core: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer with
// handshaked instruction and data ports and a 32x32 register file.
module mips_multicycle #(
  parameter logic [31:0] RESET_PC        = 32'h0000_3000,
  parameter bit          HALT_ON_ILLEGAL = 1'b1,
  parameter int          IMEM_AW         = 10,
  parameter int          DMEM_AW         = 10
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               imem_ready,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [31:0]        dmem_wdata,
  input  logic [31:0]        dmem_rdata,
  input  logic               dmem_ready,
  output logic [31:0]        pc,
  output logic               halted,
  output logic               wb_en,
  output logic [4:0]         wb_addr,
  output logic [31:0]        wb_data
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  typedef enum logic [3:0] {
    OP_ADDU, OP_SUBU, OP_SLT, OP_JR, OP_ORI, OP_LUI,
    OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL, OP_ILL
  } instr_t;

  state_t      state, next_state;
  instr_t      instr;
  logic [31:0] ir, a, b, npc, alu_out, mdr;
  logic [31:0] rf [32];
  logic [31:0] alu_res, exec_pc, sext_imm, jump_target;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;

  assign opcode      = ir[31:26];
  assign rs          = ir[25:21];
  assign rt          = ir[20:16];
  assign rd          = ir[15:11];
  assign funct       = ir[5:0];
  assign imm         = ir[15:0];
  assign sext_imm    = {{16{imm[15]}}, imm};
  assign jump_target = {npc[31:28], ir[25:0], 2'b00};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    instr = OP_ILL;
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b100001: instr = OP_ADDU;
          6'b100011: instr = OP_SUBU;
          6'b101010: instr = OP_SLT;
          6'b001000: instr = OP_JR;
          default:   instr = OP_ILL;
        endcase
      end
      6'b001101: instr = OP_ORI;
      6'b001111: instr = OP_LUI;
      6'b100011: instr = OP_LW;
      6'b101011: instr = OP_SW;
      6'b000100: instr = OP_BEQ;
      6'b000010: instr = OP_J;
      6'b000011: instr = OP_JAL;
      default:   instr = OP_ILL;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (instr)
      OP_ADDU:      alu_res = a + b;
      OP_SUBU:      alu_res = a - b;
      OP_SLT:       alu_res = {31'b0, $signed(a) < $signed(b)};
      OP_ORI:       alu_res = a | {16'h0, imm};
      OP_LUI:       alu_res = {imm, 16'h0};
      OP_LW, OP_SW: alu_res = a + sext_imm;
      default:      alu_res = '0;
    endcase
  end

  // PC chosen when EXEC returns straight to FETCH; illegal-as-NOP falls through to PC+4.
  always_comb begin
    exec_pc = npc;
    case (instr)
      OP_BEQ:  exec_pc = (a == b) ? npc + {sext_imm[29:0], 2'b00} : npc;
      OP_J:    exec_pc = jump_target;
      OP_JR:   exec_pc = a;
      default: exec_pc = npc;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH:  next_state = imem_ready ? DECODE : FETCH;
      DECODE: next_state = EXEC;
      EXEC: begin
        case (instr)
          OP_BEQ, OP_J, OP_JR: next_state = FETCH;
          OP_LW, OP_SW:        next_state = MEM;
          OP_ILL:              next_state = HALT_ON_ILLEGAL ? HALT : FETCH;
          default:             next_state = WB;
        endcase
      end
      MEM:     next_state = dmem_ready ? ((instr == OP_SW) ? FETCH : WB) : MEM;
      WB:      next_state = FETCH;
      HALT:    next_state = HALT;
      default: next_state = FETCH;
    endcase
  end

  // Requests are gated by reset so nothing is issued while reset is held.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    wb_en    = 1'b0;
    halted   = 1'b0;
    if (!reset) begin
      imem_req = (state == FETCH);
      dmem_req = (state == MEM);
      dmem_we  = (state == MEM) && (instr == OP_SW);
      wb_en    = (state == WB);
      halted   = (state == HALT);
    end
  end

  assign imem_addr  = pc[IMEM_AW+1:2];
  assign dmem_addr  = alu_out[DMEM_AW+1:2];
  assign dmem_wdata = b;
  assign wb_addr    = (instr == OP_JAL) ? 5'd31 :
                      (instr == OP_ADDU || instr == OP_SUBU || instr == OP_SLT) ? rd : rt;
  assign wb_data    = (instr == OP_LW)  ? mdr :
                      (instr == OP_JAL) ? npc : alu_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      npc     <= '0;
      alu_out <= '0;
      mdr     <= '0;
    end else begin
      case (state)
        FETCH:  if (imem_ready) ir <= imem_rdata;
        DECODE: begin
          a   <= rf[rs];
          b   <= rf[rt];
          npc <= pc + 32'd4;
        end
        EXEC: begin
          alu_out <= alu_res;
          if (next_state == FETCH) pc <= exec_pc;
        end
        MEM: if (dmem_ready) begin
          mdr <= dmem_rdata;
          if (instr == OP_SW) pc <= npc;
        end
        WB:      pc <= (instr == OP_JAL) ? jump_target : npc;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the register file is a memory that must clear on reset, so it is a flop array, not RAM.
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (state == WB && wb_addr != 5'd0) begin
      rf[wb_addr] <= wb_data;
    end
  end

endmodule

// File: tb/tb_mips_multicycle.sv
// Directed bench for mips_multicycle: behavioural instruction/data memories,
// a negedge monitor of fetches, stores and write-backs, and per-scenario tasks.
module tb_mips_multicycle;

  localparam logic [31:0] ILLEGAL = 32'hFC00_0000;

  typedef struct {logic [31:0] pc; int cyc;} fetch_t;
  typedef struct {logic [4:0] addr; logic [31:0] data; int cyc;} wb_t;
  typedef struct {logic [9:0] addr; logic [31:0] data;} st_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req, imem_ready;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [9:0]  dmem_addr;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic [31:0] pc, wb_data;
  logic        halted, wb_en;
  logic [4:0]  wb_addr;

  logic [31:0] imem [1024];
  logic [31:0] dmem [1024];
  logic        imem_ready_en = 1'b1;
  int          load_delay = 0;
  int          ld_wait = 0;
  int          cyc = 0;
  int          rel_cyc = 0;
  int          overlap = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  fetch_t fetch_q[$];
  wb_t    wb_q[$];
  st_t    st_q[$];

  always #5 clk = ~clk;

  mips_multicycle dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .pc(pc), .halted(halted), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  assign imem_rdata = imem[imem_addr];
  assign imem_ready = imem_ready_en;
  assign dmem_rdata = dmem[dmem_addr];
  // Stores complete immediately; loads wait load_delay cycles of the MEM state.
  assign dmem_ready = dmem_req && (dmem_we || ld_wait >= load_delay);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dmem_req && !dmem_ready) ld_wait <= ld_wait + 1;
    else                         ld_wait <= 0;
    if (dmem_req && dmem_we && dmem_ready) dmem[dmem_addr] <= dmem_wdata;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (imem_req && imem_ready) fetch_q.push_back('{pc, cyc});
      if (wb_en) wb_q.push_back('{wb_addr, wb_data, cyc});
      if (dmem_req && dmem_we && dmem_ready) st_q.push_back('{dmem_addr, dmem_wdata});
      if (imem_req && dmem_req) overlap++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    fetch_q.delete();
    wb_q.delete();
    st_q.delete();
    reset   = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic wait_halt(input int budget, input string name);
    int n = 0;
    while (!halted && n < budget) begin
      tick();
      n++;
    end
    n_checks++;
    if (halted !== 1'b1) $display("FAIL %s: halted=%b after %0d cycles, expected 1", name, halted, budget);
    else n_pass++;
  endtask

  task automatic wait_fetches(input int cnt, input int budget, input string name);
    int n = 0;
    while (fetch_q.size() < cnt && n < budget) begin
      tick();
      n++;
    end
    n_checks++;
    if (fetch_q.size() < cnt) $display("FAIL %s: %0d fetches seen, expected %0d", name, fetch_q.size(), cnt);
    else n_pass++;
  endtask

  task automatic test_reset();
    logic [5:0] got, exp;
    reset = 1'b1;
    tick();
    tick();
    got = {pc == 32'h3000, halted, imem_req, dmem_req, dmem_we, wb_en};
    exp = 6'b100000;
    n_checks++;
    if (got !== exp) $display("FAIL reset_state: {pc_ok,halted,ireq,dreq,we,wb}=%b expected %b", got, exp);
    else n_pass++;
    imem_ready_en = 1'b0;
    reset = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 10'd0) $display("FAIL fetch_hold_req: req=%b addr=%h expected 1/000", imem_req, imem_addr);
    else n_pass++;
    n_checks++;
    if (fetch_q.size() != 0 || pc !== 32'h3000) $display("FAIL fetch_hold_progress: fetches=%0d pc=%h expected 0/00003000", fetch_q.size(), pc);
    else n_pass++;
    imem_ready_en = 1'b1;
    wait_fetches(1, 5, "fetch_after_ready");
  endtask

  task automatic test_alu_mem();
    imem[0] = 32'h3401_1234;  // ori  $1,$0,0x1234
    imem[1] = 32'h0021_1021;  // addu $2,$1,$1
    imem[2] = 32'hAC02_0004;  // sw   $2,4($0)
    imem[3] = 32'h8C03_0004;  // lw   $3,4($0)
    imem[4] = ILLEGAL;
    load_delay = 3;
    do_reset();
    wait_halt(200, "alu_mem_halt");
    n_checks++;
    if (fetch_q.size() != 5 || fetch_q[0].cyc != rel_cyc) $display("FAIL first_fetch: fetches=%0d cyc=%0d expected 5/%0d", fetch_q.size(), fetch_q[0].cyc, rel_cyc);
    else n_pass++;
    n_checks++;
    if (wb_q.size() != 3) $display("FAIL alu_mem_wb_count: got %0d expected 3", wb_q.size());
    else n_pass++;
    n_checks++;
    if (wb_q[0].addr !== 5'd1 || wb_q[0].data !== 32'h1234) $display("FAIL ori_wb: got ($%0d,%h) expected ($1,00001234)", wb_q[0].addr, wb_q[0].data);
    else n_pass++;
    n_checks++;
    if (wb_q[1].addr !== 5'd2 || wb_q[1].data !== 32'h2468) $display("FAIL addu_wb: got ($%0d,%h) expected ($2,00002468)", wb_q[1].addr, wb_q[1].data);
    else n_pass++;
    n_checks++;
    if (wb_q[1].cyc - fetch_q[0].cyc + 1 != 8) $display("FAIL ori_addu_cycles: got %0d expected 8", wb_q[1].cyc - fetch_q[0].cyc + 1);
    else n_pass++;
    n_checks++;
    if (st_q.size() != 1 || st_q[0].addr !== 10'd1 || st_q[0].data !== 32'h2468) $display("FAIL sw_access: n=%0d addr=%h data=%h expected 1/001/00002468", st_q.size(), st_q[0].addr, st_q[0].data);
    else n_pass++;
    n_checks++;
    if (fetch_q[3].cyc - fetch_q[2].cyc != 4) $display("FAIL sw_cycles: got %0d expected 4", fetch_q[3].cyc - fetch_q[2].cyc);
    else n_pass++;
    n_checks++;
    if (wb_q[2].addr !== 5'd3 || wb_q[2].data !== 32'h2468) $display("FAIL lw_wb: got ($%0d,%h) expected ($3,00002468)", wb_q[2].addr, wb_q[2].data);
    else n_pass++;
    n_checks++;
    if (fetch_q[4].cyc - fetch_q[3].cyc != 8) $display("FAIL lw_cycles: got %0d expected 8", fetch_q[4].cyc - fetch_q[3].cyc);
    else n_pass++;
    load_delay = 0;
  endtask

  task automatic test_alu_ops();
    logic [4:0]  exp_addr [7] = '{5'd0, 5'd6, 5'd7, 5'd8, 5'd11, 5'd9, 5'd10};
    logic [31:0] exp_data [7] = '{32'h77, 32'h0, 32'h8000_0000, 32'h1, 32'h0, 32'hFFFF_FFFF, 32'h0000_FFFF};
    imem[0] = 32'h3400_0077;  // ori  $0,$0,0x77 (discarded)
    imem[1] = 32'h0000_3021;  // addu $6,$0,$0
    imem[2] = 32'h3C07_8000;  // lui  $7,0x8000
    imem[3] = 32'h00E0_402A;  // slt  $8,$7,$0
    imem[4] = 32'h0007_582A;  // slt  $11,$0,$7
    imem[5] = 32'h0008_4823;  // subu $9,$0,$8
    imem[6] = 32'h340A_FFFF;  // ori  $10,$0,0xFFFF
    imem[7] = ILLEGAL;
    do_reset();
    wait_halt(200, "alu_ops_halt");
    n_checks++;
    if (wb_q.size() != 7) $display("FAIL alu_ops_wb_count: got %0d expected 7", wb_q.size());
    else n_pass++;
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (wb_q[i].addr !== exp_addr[i] || (i != 0 && wb_q[i].data !== exp_data[i]))
        $display("FAIL alu_ops_wb[%0d]: got ($%0d,%h) expected ($%0d,%h)", i, wb_q[i].addr, wb_q[i].data, exp_addr[i], exp_data[i]);
      else n_pass++;
    end
    n_checks++;
    if (fetch_q[4].cyc - fetch_q[3].cyc != 4) $display("FAIL rtype_cycles: got %0d expected 4", fetch_q[4].cyc - fetch_q[3].cyc);
    else n_pass++;
  endtask

  task automatic test_branch();
    imem[0] = 32'h3401_0001;  // ori $1,$0,1
    imem[1] = 32'h3402_0005;  // ori $2,$0,5
    imem[2] = 32'h1000_FFFF;  // beq $0,$0,-1
    imem[3] = ILLEGAL;
    do_reset();
    wait_fetches(5, 100, "beq_taken_fetches");
    n_checks++;
    if (fetch_q[3].pc !== 32'h3008 || fetch_q[4].pc !== 32'h3008) $display("FAIL beq_taken_pc: got %h,%h expected 00003008", fetch_q[3].pc, fetch_q[4].pc);
    else n_pass++;
    n_checks++;
    if (fetch_q[3].cyc - fetch_q[2].cyc != 3 || halted !== 1'b0) $display("FAIL beq_taken_cycles: got %0d halted=%b expected 3/0", fetch_q[3].cyc - fetch_q[2].cyc, halted);
    else n_pass++;
    imem[2] = 32'h1020_FFFF;  // beq $1,$0,-1 ($1 != 0)
    do_reset();
    wait_halt(100, "beq_not_taken_halt");
    n_checks++;
    if (fetch_q.size() != 4 || fetch_q[3].pc !== 32'h300C) $display("FAIL beq_not_taken_pc: n=%0d pc=%h expected 4/0000300c", fetch_q.size(), fetch_q[3].pc);
    else n_pass++;
    n_checks++;
    if (fetch_q[3].cyc - fetch_q[2].cyc != 3) $display("FAIL beq_not_taken_cycles: got %0d expected 3", fetch_q[3].cyc - fetch_q[2].cyc);
    else n_pass++;
  endtask

  task automatic test_jal_jr();
    logic [31:0] exp_pc [5] = '{32'h3000, 32'h3010, 32'h3000, 32'h3004, 32'h3014};
    imem[0] = 32'h13E0_0003;  // beq $31,$0,+3
    imem[1] = 32'h03E0_0008;  // jr  $31
    imem[2] = ILLEGAL;
    imem[3] = ILLEGAL;
    imem[4] = 32'h0C00_0C00;  // jal 0x0C00
    imem[5] = ILLEGAL;
    do_reset();
    wait_halt(100, "jal_jr_halt");
    n_checks++;
    if (fetch_q.size() != 5) $display("FAIL jal_jr_fetch_count: got %0d expected 5", fetch_q.size());
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (fetch_q[i].pc !== exp_pc[i]) $display("FAIL jal_jr_pc[%0d]: got %h expected %h", i, fetch_q[i].pc, exp_pc[i]);
      else n_pass++;
    end
    n_checks++;
    if (wb_q.size() != 1 || wb_q[0].addr !== 5'd31 || wb_q[0].data !== 32'h3014) $display("FAIL jal_wb: n=%0d ($%0d,%h) expected 1 ($31,00003014)", wb_q.size(), wb_q[0].addr, wb_q[0].data);
    else n_pass++;
    n_checks++;
    if (fetch_q[2].cyc - fetch_q[1].cyc != 4 || fetch_q[4].cyc - fetch_q[3].cyc != 3) $display("FAIL jal_jr_cycles: jal=%0d jr=%0d expected 4/3", fetch_q[2].cyc - fetch_q[1].cyc, fetch_q[4].cyc - fetch_q[3].cyc);
    else n_pass++;
  endtask

  task automatic test_illegal();
    int bad = 0;
    imem[0] = 32'h3401_0001;  // ori $1,$0,1
    imem[1] = ILLEGAL;
    do_reset();
    wait_halt(50, "illegal_halt");
    n_checks++;
    if (pc !== 32'h3004) $display("FAIL illegal_pc: got %h expected 00003004", pc);
    else n_pass++;
    repeat (20) begin
      tick();
      if (pc !== 32'h3004 || halted !== 1'b1 || imem_req !== 1'b0 || dmem_req !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL halt_frozen: %0d bad cycles expected 0", bad);
    else n_pass++;
    reset = 1'b1;
    tick();
    n_checks++;
    if (pc !== 32'h3000 || halted !== 1'b0) $display("FAIL halt_reset: pc=%h halted=%b expected 00003000/0", pc, halted);
    else n_pass++;
  endtask

  task automatic test_reset_mid_mem();
    int n = 0;
    imem[0] = 32'h3402_0055;  // ori $2,$0,0x55
    imem[1] = 32'h8C03_0004;  // lw  $3,4($0)
    imem[2] = ILLEGAL;
    load_delay = 1000;
    do_reset();
    while (!dmem_req && n < 50) begin
      tick();
      n++;
    end
    tick();
    tick();
    n_checks++;
    if (dmem_req !== 1'b1 || wb_q.size() != 1) $display("FAIL mem_wait: dreq=%b wbs=%0d expected 1/1", dmem_req, wb_q.size());
    else n_pass++;
    reset = 1'b1;
    tick();
    n_checks++;
    if (dmem_req !== 1'b0 || imem_req !== 1'b0) $display("FAIL mem_reset_drop: dreq=%b ireq=%b expected 0/0", dmem_req, imem_req);
    else n_pass++;
    imem[0] = 32'h0040_2821;  // addu $5,$2,$0
    imem[1] = ILLEGAL;
    load_delay = 0;
    do_reset();
    wait_halt(50, "mem_reset_halt");
    n_checks++;
    if (fetch_q[0].pc !== 32'h3000 || fetch_q[0].cyc != rel_cyc) $display("FAIL mem_reset_fetch: pc=%h cyc=%0d expected 00003000/%0d", fetch_q[0].pc, fetch_q[0].cyc, rel_cyc);
    else n_pass++;
    n_checks++;
    if (wb_q.size() != 1 || wb_q[0].addr !== 5'd5 || wb_q[0].data !== 32'h0) $display("FAIL regfile_cleared: n=%0d ($%0d,%h) expected 1 ($5,00000000)", wb_q.size(), wb_q[0].addr, wb_q[0].data);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      imem[i] = ILLEGAL;
      dmem[i] = '0;
    end
    test_reset();
    test_alu_mem();
    test_alu_ops();
    test_branch();
    test_jal_jr();
    test_illegal();
    test_reset_mid_mem();
    n_checks++;
    if (overlap != 0) $display("FAIL req_overlap: %0d cycles with both requests expected 0", overlap);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
